// File: rtl/hrm_mmio_pkg.sv
// Shared definitions for the MMIO fabric: FSM state encoding and the default slot map.
package hrm_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAM_WAIT  = 2'd1,
    SLOT_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  // XALU, LEDS, RAND, plus a spare slot whose base can never match under a zero mask
  localparam int unsigned DEF_N_SLOTS   = 4;
  localparam logic [31:0] DEF_SLOT_BASE = {8'hFF, 8'h11, 8'h10, 8'h00};
  localparam logic [31:0] DEF_SLOT_MASK = {8'h00, 8'hFF, 8'hFF, 8'hF0};

endpackage

// File: rtl/mmio_fabric_if.sv
// CPU-side request/acknowledge bus of the MMIO fabric.
interface mmio_fabric_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic                  mmio;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] dout;
  logic                  busy;

  modport master (output req, we, mmio, addr, din, input  ack, err, dout, busy);
  modport slave  (input  req, we, mmio, addr, din, output ack, err, dout, busy);
endinterface

// File: rtl/mmio_decoder.sv
// Mask/base priority decode of an address onto the peripheral slots; lowest index wins.
module mmio_decoder #(
  parameter int unsigned                   ADDR_WIDTH = 8,
  parameter int unsigned                   N_SLOTS    = 4,
  parameter int unsigned                   IDX_W      = 2,
  parameter logic [N_SLOTS*ADDR_WIDTH-1:0] SLOT_BASE  = '0,
  parameter logic [N_SLOTS*ADDR_WIDTH-1:0] SLOT_MASK  = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit_c,
  output logic [N_SLOTS-1:0]    sel_c,
  output logic [IDX_W-1:0]      idx_c
);

  always_comb begin
    hit_c = 1'b0;
    sel_c = '0;
    idx_c = '0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if ((addr & SLOT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLOT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_c = 1'b1;
        sel_c = N_SLOTS'(1) << i;
        idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_fabric.sv
// Routes CPU accesses to RAM or to an MMIO slot with wait states, timeout and registered response.
module mmio_fabric
  import hrm_mmio_pkg::*;
#(
  parameter int unsigned                   DATA_WIDTH  = 8,
  parameter int unsigned                   ADDR_WIDTH  = 8,
  parameter int unsigned                   N_SLOTS     = DEF_N_SLOTS,
  parameter logic [N_SLOTS*ADDR_WIDTH-1:0] SLOT_BASE   = DEF_SLOT_BASE,
  parameter logic [N_SLOTS*ADDR_WIDTH-1:0] SLOT_MASK   = DEF_SLOT_MASK,
  parameter int unsigned                   RAM_LATENCY = 1,
  parameter int unsigned                   TIMEOUT     = 15,
  parameter logic [DATA_WIDTH-1:0]         ERR_DATA    = DATA_WIDTH'(8'hFF)
) (
  input  logic                            clk,
  input  logic                            rst,
  mmio_fabric_if.slave                    bus,
  output logic                            ram_we,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_din,
  input  logic [DATA_WIDTH-1:0]           ram_dout,
  output logic [N_SLOTS-1:0]              slot_cs,
  output logic                            slot_we,
  output logic [ADDR_WIDTH-1:0]           slot_addr,
  output logic [DATA_WIDTH-1:0]           slot_din,
  input  logic [N_SLOTS*DATA_WIDTH-1:0]   slot_dout,
  input  logic [N_SLOTS-1:0]              slot_rdy
);

  localparam int unsigned CNT_MAX = (TIMEOUT > RAM_LATENCY) ? TIMEOUT : RAM_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_SLOTS-1:0]    cs_q, cs_d;
  logic                  swe_q, swe_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  dec_hit;
  logic [N_SLOTS-1:0]    dec_sel;
  logic [IDX_W-1:0]      dec_idx;
  logic                  rdy_sel;
  logic [DATA_WIDTH-1:0] sdout_sel;

  mmio_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_SLOTS    (N_SLOTS),
    .IDX_W      (IDX_W),
    .SLOT_BASE  (SLOT_BASE),
    .SLOT_MASK  (SLOT_MASK)
  ) u_decoder (
    .addr  (bus.addr),
    .hit_c (dec_hit),
    .sel_c (dec_sel),
    .idx_c (dec_idx)
  );

  // Read mux of the latched target slot
  always_comb begin
    rdy_sel   = 1'b0;
    sdout_sel = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        rdy_sel   = slot_rdy[i];
        sdout_sel = slot_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = we_q;
    idx_d    = idx_q;
    cs_d     = cs_q;
    swe_d    = swe_q;
    ram_we_d = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dout_d   = dout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d = bus.addr;
          din_d  = bus.din;
          we_d   = bus.we;
          cnt_d  = '0;
          if (!bus.mmio) begin
            state_d  = RAM_WAIT;
            ram_we_d = bus.we;
          end else if (dec_hit) begin
            state_d = SLOT_WAIT;
            idx_d   = dec_idx;
            cs_d    = dec_sel;
            swe_d   = bus.we;
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      RAM_WAIT: begin
        if (we_q) begin
          state_d = RESP;
          ack_d   = 1'b1;
        end else if (cnt_q == CNT_W'(RAM_LATENCY)) begin
          dout_d  = ram_dout;
          state_d = RESP;
          ack_d   = 1'b1;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SLOT_WAIT: begin
        // Ready wins over timeout when both land in the same cycle
        if (rdy_sel) begin
          if (!we_q) dout_d = sdout_sel;
          state_d = RESP;
          ack_d   = 1'b1;
          cs_d    = '0;
          swe_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          dout_d  = ERR_DATA;
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          cs_d    = '0;
          swe_d   = 1'b0;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      cs_q     <= '0;
      swe_q    <= 1'b0;
      ram_we_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      cs_q     <= cs_d;
      swe_q    <= swe_d;
      ram_we_q <= ram_we_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.dout  = dout_q;
  assign bus.busy  = busy_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign slot_cs   = cs_q;
  assign slot_we   = swe_q;
  assign slot_addr = addr_q;
  assign slot_din  = din_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Scoreboard bench for mmio_fabric: directed spec scenarios followed by randomized RAM/MMIO traffic.
module tb_mmio_fabric;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned NS = 3;
  localparam int          RAM_LAT = 1;
  localparam int          TMO = 15;
  localparam logic [NS*AW-1:0] BASE = {8'h11, 8'h10, 8'h00};
  localparam logic [NS*AW-1:0] MASK = {8'hFF, 8'hFF, 8'hF0};
  localparam logic [7:0] ERRD = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mmio_fabric_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [NS-1:0] slot_cs;
  logic          slot_we;
  logic [AW-1:0] slot_addr;
  logic [DW-1:0] slot_din;
  logic [NS*DW-1:0] slot_dout;
  logic [NS-1:0] slot_rdy;

  mmio_fabric #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_SLOTS(NS), .SLOT_BASE(BASE), .SLOT_MASK(MASK),
    .RAM_LATENCY(RAM_LAT), .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .slot_cs(slot_cs), .slot_we(slot_we), .slot_addr(slot_addr), .slot_din(slot_din),
    .slot_dout(slot_dout), .slot_rdy(slot_rdy)
  );

  // Environment: synchronous RAM and register-like slots with programmable wait
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  logic [7:0] slot_reg [3] = '{8'h5A, 8'h00, 8'hA5};
  int cs_cnt [3] = '{0, 0, 0};
  int slot_wait [3] = '{0, 0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (slot_cs[i] && slot_we && slot_rdy[i]) slot_reg[i] <= slot_din;
      cs_cnt[i] <= slot_cs[i] ? cs_cnt[i] + 1 : 0;
    end
  end
  always_comb begin
    for (int i = 0; i < 3; i++)
      slot_rdy[i] = (slot_wait[i] == 0) || (slot_cs[i] && (cs_cnt[i] >= slot_wait[i]));
  end
  assign slot_dout = {slot_reg[2], slot_reg[1], slot_reg[0]};

  // Reference model state
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] ref_slot [3] = '{8'h5A, 8'h00, 8'hA5};
  logic [7:0] ref_dout = 8'h00;
  logic [7:0] m_base [3] = '{8'h00, 8'h10, 8'h11};
  logic [7:0] m_mask [3] = '{8'hF0, 8'hFF, 8'hFF};

  typedef struct {
    logic       err;
    logic [7:0] dout;
    int         lat;
    int         t0;
  } exp_t;
  exp_t sbq[$];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every ack pops one expected response
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (bus.ack) begin
        if (sbq.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_ack: actual=ack required=no ack (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("ack_latency", cyc - e.t0, e.lat);
          chk("err", int'(bus.err), int'(e.err));
          chk("dout", int'(bus.dout), int'(e.dout));
        end
      end else begin
        chk("err_without_ack", int'(bus.err), 0);
      end
    end
  end

  task automatic do_txn(input logic twe, input logic tmmio, input logic [7:0] ta,
                        input logic [7:0] td, input bit poke);
    exp_t e;
    int s, w, exp_cs, exp_csn, exp_ramwe, n_cs, n_ramwe;
    logic [2:0] cs_t1;
    logic ramwe_t1;
    bit got;
    s = -1;
    for (int i = 2; i >= 0; i--) if ((ta & m_mask[i]) == m_base[i]) s = i;
    e.err = 1'b0; exp_cs = 0; exp_csn = 0; exp_ramwe = 0;
    if (!tmmio) begin
      if (twe) begin ref_mem[ta] = td; e.lat = 2; exp_ramwe = 1; end
      else begin ref_dout = ref_mem[ta]; e.lat = 2 + RAM_LAT; end
    end else if (s < 0) begin
      e.err = 1'b1; e.lat = 1;
    end else begin
      w = slot_wait[s];
      exp_cs = 1 << s;
      if (w <= TMO) begin
        e.lat = w + 2; exp_csn = w + 1;
        if (twe) ref_slot[s] = td; else ref_dout = ref_slot[s];
      end else begin
        e.err = 1'b1; e.lat = TMO + 2; exp_csn = TMO + 1; ref_dout = ERRD;
      end
    end
    e.dout = ref_dout;

    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!bus.busy) begin got = 1'b1; break; end
    end
    if (!got) begin chk("idle_wait", 0, 1); return; end
    bus.req = 1'b1; bus.we = twe; bus.mmio = tmmio; bus.addr = ta; bus.din = td;
    e.t0 = cyc;
    sbq.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
    cs_t1 = slot_cs; ramwe_t1 = ram_we; n_cs = 0; n_ramwe = 0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (|slot_cs) n_cs++;
      if (ram_we) n_ramwe++;
      if (bus.ack) begin got = 1'b1; break; end
      if (poke) begin
        bus.req = (k == 3); bus.mmio = 1'b0; bus.we = 1'b1; bus.addr = 8'h30; bus.din = 8'h77;
      end
      @(negedge clk);
    end
    bus.req = 1'b0;
    chk("ack_seen", int'(got), 1);
    chk("cs_at_t1", int'(cs_t1), exp_cs);
    chk("cs_cycles", n_cs, exp_csn);
    chk("ram_we_at_t1", int'(ramwe_t1), exp_ramwe);
    chk("ram_we_cycles", n_ramwe, exp_ramwe);
  endtask

  initial begin : stim
    logic tmm, twe;
    logic [7:0] ta;
    bus.req = 1'b0; bus.we = 1'b0; bus.mmio = 1'b0; bus.addr = '0; bus.din = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_cs", int'(slot_cs), 0);
    rst = 1'b1;

    do_txn(1'b1, 1'b0, 8'h20, 8'h3C, 1'b0);
    do_txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0);
    slot_wait[2] = 0;
    do_txn(1'b0, 1'b1, 8'h11, 8'h00, 1'b0);
    slot_wait[0] = 3;
    do_txn(1'b0, 1'b1, 8'h05, 8'h00, 1'b0);
    do_txn(1'b0, 1'b1, 8'h80, 8'h00, 1'b0);
    slot_wait[1] = 255;
    do_txn(1'b0, 1'b1, 8'h10, 8'h00, 1'b1);
    do_txn(1'b0, 1'b0, 8'h30, 8'h00, 1'b0);
    do_txn(1'b1, 1'b1, 8'h10, 8'hC3, 1'b0);
    slot_wait[1] = TMO;
    do_txn(1'b1, 1'b1, 8'h10, 8'h4B, 1'b0);
    do_txn(1'b0, 1'b1, 8'h10, 8'h00, 1'b0);

    // Reset while a slot access is waiting
    slot_wait[1] = 255;
    @(negedge clk);
    bus.req = 1'b1; bus.mmio = 1'b1; bus.we = 1'b0; bus.addr = 8'h10;
    @(negedge clk);
    bus.req = 1'b0;
    chk("cs_before_reset", int'(slot_cs), 2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_cs", int'(slot_cs), 0);
    chk("midrst_ack", int'(bus.ack), 0);
    chk("midrst_dout", int'(bus.dout), 0);
    rst = 1'b1;
    ref_dout = 8'h00;
    do_txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0);

    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 3; i++) begin
        int r;
        r = int'($urandom_range(0, 15));
        slot_wait[i] = (r == 0) ? 255 : (r % 6);
      end
      tmm = 1'($urandom_range(0, 1));
      twe = 1'($urandom_range(0, 1));
      if (!tmm) ta = 8'h20 + 8'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 3))
          0: ta = 8'($urandom_range(0, 15));
          1: ta = 8'h10;
          2: ta = 8'h11;
          default: ta = 8'($urandom_range(0, 255));
        endcase
      end
      do_txn(twe, tmm, ta, 8'($urandom_range(0, 255)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
